// File: rtl/rr_arb_4_sel.sv
// rr_arb_4_sel: 4-channel round-robin arbiter with a single-entry registered output slot.
// Optional per-channel saturating grant counters are enabled by defining RR_ARB_GRANT_CNT_EN.
module rr_arb_4_sel #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    output logic [3:0]   in_ready,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel
`ifdef RR_ARB_GRANT_CNT_EN
    ,
    output logic [7:0]   grant_cnt0,
    output logic [7:0]   grant_cnt1,
    output logic [7:0]   grant_cnt2,
    output logic [7:0]   grant_cnt3
`endif
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state;
    logic [1:0] ptr;
    logic [7:0] rot_dbl;
    logic [3:0] rot;
    logic [1:0] off;
    logic [1:0] g;
    logic gnt_any;
    logic load_ok;
    logic load;
    logic [W-1:0] d_g;
    // rotate requests so ptr sits at bit 0, pick the first set bit, map back to a channel index
    always_comb begin
        rot_dbl = {in_valid, in_valid} >> ptr;
        rot = rot_dbl[3:0];
        off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        g = ptr + off;
        gnt_any = |in_valid;
        load_ok = (state == EMPTY) | out_ready;
        load = rst & load_ok & gnt_any;
        in_ready = load ? (4'b0001 << g) : 4'b0000;
        d_g = (g == 2'd0) ? d0 : (g == 2'd1) ? d1 : (g == 2'd2) ? d2 : d3;
    end
    // output slot FSM: load winner on a grant, drain when downstream takes it with nothing new
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= EMPTY;
            out_valid <= 1'b0;
            out_data <= '0;
            out_sel <= 2'd0;
            ptr <= 2'd0;
        end else if (load) begin
            state <= FULL;
            out_valid <= 1'b1;
            out_data <= d_g;
            out_sel <= g;
            ptr <= g + 2'd1;
        end else if (out_ready) begin
            state <= EMPTY;
            out_valid <= 1'b0;
        end
    end
`ifdef RR_ARB_GRANT_CNT_EN
    logic [7:0] cnt [4];
    for (genvar i = 0; i < 4; i++) begin : g_cnt
        // count accepted transfers per channel, sticking at 255
        always_ff @(posedge clk) begin
            if (!rst) cnt[i] <= 8'd0;
            else if (in_ready[i] && cnt[i] != 8'hFF) cnt[i] <= cnt[i] + 8'd1;
        end
    end
    assign grant_cnt0 = cnt[0];
    assign grant_cnt1 = cnt[1];
    assign grant_cnt2 = cnt[2];
    assign grant_cnt3 = cnt[3];
`endif
endmodule

// File: tb/tb_rr_arb_4_sel.sv
// tb_rr_arb_4_sel: table-driven self-checking bench for rr_arb_4_sel (counters checked when RR_ARB_GRANT_CNT_EN is defined).
module tb_rr_arb_4_sel;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] in_valid = 4'b0;
    logic [3:0] in_ready;
    logic [3:0] d0 = 4'h1, d1 = 4'h2, d2 = 4'h3, d3 = 4'h4;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [3:0] out_data;
    logic [1:0] out_sel;
    int checks = 0;
    int failures = 0;
`ifdef RR_ARB_GRANT_CNT_EN
    logic [7:0] grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3;
`endif

    rr_arb_4_sel #(.W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel)
`ifdef RR_ARB_GRANT_CNT_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .grant_cnt2(grant_cnt2), .grant_cnt3(grant_cnt3)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r;
        logic [3:0] iv;
        logic [3:0] a0, a1, a2, a3;
        logic ordy;
        logic [3:0] eir;
        logic eov;
        logic [3:0] eod;
        logic [1:0] eos;
    } vec_t;
    vec_t v[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // r  iv       d0    d1    d2    d3   ordy eir     eov eod   eos
        v.push_back('{0, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0000, 0, 4'h0, 2'd0});
        v.push_back('{0, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0000, 0, 4'h0, 2'd0});
        v.push_back('{1, 4'b0100, 4'h1, 4'h2, 4'hA, 4'h4, 1, 4'b0100, 1, 4'hA, 2'd2});
        v.push_back('{0, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0000, 0, 4'h0, 2'd0});
        v.push_back('{1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0001, 1, 4'h1, 2'd0});
        v.push_back('{1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0010, 1, 4'h2, 2'd1});
        v.push_back('{1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0100, 1, 4'h3, 2'd2});
        v.push_back('{1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b1000, 1, 4'h4, 2'd3});
        v.push_back('{1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0001, 1, 4'h1, 2'd0});
        v.push_back('{1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0010, 1, 4'h2, 2'd1});
        v.push_back('{1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 0, 4'b0000, 1, 4'h2, 2'd1});
        v.push_back('{1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 0, 4'b0000, 1, 4'h2, 2'd1});
        v.push_back('{1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 0, 4'b0000, 1, 4'h2, 2'd1});
        v.push_back('{1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0100, 1, 4'h3, 2'd2});
        v.push_back('{1, 4'b0010, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0010, 1, 4'h2, 2'd1});
        v.push_back('{1, 4'b0000, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0000, 0, 4'h2, 2'd1});
        v.push_back('{1, 4'b0000, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0000, 0, 4'h2, 2'd1});
        v.push_back('{1, 4'b1000, 4'h1, 4'h2, 4'h3, 4'h4, 0, 4'b1000, 1, 4'h4, 2'd3});
        v.push_back('{1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 0, 4'b0000, 1, 4'h4, 2'd3});
        v.push_back('{0, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0000, 0, 4'h0, 2'd0});
        v.push_back('{1, 4'b0110, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0010, 1, 4'h2, 2'd1});
        v.push_back('{1, 4'b0110, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0100, 1, 4'h3, 2'd2});
        v.push_back('{1, 4'b0110, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0010, 1, 4'h2, 2'd1});

        for (int i = 0; i < v.size(); i++) begin
            rst = v[i].r;
            in_valid = v[i].iv;
            d0 = v[i].a0; d1 = v[i].a1; d2 = v[i].a2; d3 = v[i].a3;
            out_ready = v[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(v[i].eir));
            tick();
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(v[i].eov));
            chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(v[i].eod));
            chk($sformatf("v%0d_out_sel", i), 32'(out_sel), 32'(v[i].eos));
        end

        // fairness: all channels valid from reset, grants must cycle 0,1,2,3,...
        rst = 1'b0;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        d0 = 4'h5; d1 = 4'h6; d2 = 4'h7; d3 = 4'h8;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("fair%0d_sel", k), 32'(out_sel), 32'(k % 4));
            chk($sformatf("fair%0d_data", k), 32'(out_data), 32'(k % 4 + 5));
            chk($sformatf("fair%0d_valid", k), 32'(out_valid), 32'd1);
        end

`ifdef RR_ARB_GRANT_CNT_EN
        // saturation: 300 grants to channel 0
        rst = 1'b0;
        tick();
        rst = 1'b1;
        in_valid = 4'b0001;
        out_ready = 1'b1;
        for (int k = 0; k < 300; k++) tick();
        chk("cnt0_sat", 32'(grant_cnt0), 32'd255);
        chk("cnt1_zero", 32'(grant_cnt1), 32'd0);
        chk("cnt2_zero", 32'(grant_cnt2), 32'd0);
        chk("cnt3_zero", 32'(grant_cnt3), 32'd0);
        rst = 1'b0;
        tick();
        chk("cnt0_rst", 32'(grant_cnt0), 32'd0);
        chk("cnt_rst_any", 32'(grant_cnt1 | grant_cnt2 | grant_cnt3), 32'd0);
        rst = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_arb_4_sel.md
Name: rr_arb_4_sel

Overview:
- Round-robin arbiter and single-entry output register placed directly upstream of the 4:1 mux datapath.
- Takes four valid/ready request channels, each carrying W-bit data.
- Picks one channel per accepted transfer and presents the winning data together with its 2-bit select index.
- Downstream 4:1 mux stages and consumers use out_sel as their sel and out_data/out_valid as the registered payload.

Parameters:
- W, 4, data width of every input channel and of out_data.

Ports:
- clk        input   1        rising-edge clock
- rst        input   1        synchronous reset, active-low (asserted when 0)
- in_valid   input   4        per-channel request; bit i belongs to channel i
- in_ready   output  4        per-channel accept; one-hot or zero
- d0         input   W        channel 0 data
- d1         input   W        channel 1 data
- d2         input   W        channel 2 data
- d3         input   W        channel 3 data
- out_valid  output  1        out_data/out_sel hold a valid entry
- out_ready  input   1        downstream accepts the entry this cycle
- out_data   output  W        registered data of the granted channel
- out_sel    output  2        registered index of the granted channel

Behaviour:
- Reset is synchronous: sampled on a clk rising edge while rst==0.
  - out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0.
  - in_ready=0 during reset.
- State is a single output slot with two states:
  - EMPTY when out_valid==0.
  - FULL when out_valid==1.
- load_ok = (state==EMPTY) | out_ready.
- Arbitration is combinational:
  - Scan in_valid starting at index ptr, wrapping ptr, ptr+1, ..., ptr+3 mod 4.
  - The first set bit is grant index g.
  - No set bit means no grant.
- in_ready[g]=1 only when load_ok & a grant exists; all other bits are 0.
  - in_ready may depend combinationally on in_valid.
  - Upstream must not wait for in_ready before raising in_valid.
- Transfer on channel i occurs in a cycle with in_valid[i] & in_ready[i]. At the next clk edge:
  - out_data <= d_g, out_sel <= g, out_valid <= 1.
  - ptr <= (g+1) mod 4, wrapping 3 -> 0.
- Downstream handshake:
  - FULL & out_ready & no grant -> out_valid <= 0; out_data and out_sel keep their last values.
  - FULL & !out_ready -> all outputs hold; in_ready=0; ptr holds.
  - FULL & out_ready & grant -> back-to-back reload in the same edge. Throughput is 1 transfer/cycle.
- Latency: 1 cycle from accepted input to out_valid.
- ptr changes only on a grant. With no requests it holds its value indefinitely.
- An input channel that drops in_valid before being granted loses nothing and incurs no penalty.
- Reset asserted mid-transfer:
  - Any FULL entry is discarded.
  - No in_ready is asserted in the reset cycle.
  - The pointer returns to 0.
- Fairness: with all four channels continuously valid and out_ready=1, grants follow 0,1,2,3,0,...

Optional Feature:
- Macro: RR_ARB_GRANT_CNT_EN.
- Defined:
  - Adds output ports grant_cnt0..grant_cnt3, each 8 bits.
  - Each counter increments on its channel's accepted transfer and saturates at 255, no wrap.
  - All counters clear to 0 on reset.
- Not defined:
  - The ports and counters do not exist.
  - Behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, out_sel=0, in_ready=4'b0000 throughout.
- Single channel: release reset, in_valid=4'b0100, d2=4'hA, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=4'hA, out_sel=2; ptr becomes 3.
- Round-robin: in_valid=4'b1111, d0..d3 = 4'h1,4'h2,4'h3,4'h4, out_ready=1 for 5 cycles from reset -> out_sel sequence 0,1,2,3,0 and out_data 1,2,3,4,1, with out_valid=1 each cycle.
- Backpressure: out_ready=0 while FULL with out_sel=1 for 3 cycles, in_valid=4'b1111 -> in_ready=0, outputs frozen; on out_ready=1, grant goes to channel 2.
- Wrap and skip: ptr=3, in_valid=4'b0010 -> grant 1, out_sel=1, ptr becomes 2; then in_valid=0 with out_ready=1 -> out_valid drops to 0 and out_sel holds at 1.
- Optional, with RR_ARB_GRANT_CNT_EN: 300 consecutive grants to channel 0 -> grant_cnt0=255, grant_cnt1..3=0; reset -> all counters 0.
